// File: rtl/uart_distance_parser.sv
// uart_distance_parser
// Receive-side decoder for "distance: <digits>cm\n" frames popped from a
// show-ahead UART RX FIFO. Valid frames update a 16-bit distance with a
// one-cycle strobe; malformed, overlong or stalled frames raise a one-cycle
// error strobe with a held cause code, then the parser resynchronises on '\n'.
module uart_distance_parser #(
  parameter int MAX_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rd,
  output logic [15:0] distance,
  output logic        dist_valid,
  output logic        frame_err,
  output logic [2:0]  err_code
);

  typedef enum logic [2:0] {
    ST_PREFIX = 3'd0,
    ST_DIGIT  = 3'd1,
    ST_UNIT_M = 3'd2,
    ST_EOL    = 3'd3,
    ST_RESYNC = 3'd4
  } state_t;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_C  = 8'h63;
  localparam logic [7:0] CH_M  = 8'h6D;

  localparam logic [2:0] ERR_PREFIX  = 3'd1;
  localparam logic [2:0] ERR_CHAR    = 3'd2;
  localparam logic [2:0] ERR_OVERFL  = 3'd3;
  localparam logic [2:0] ERR_NODIG   = 3'd4;
  localparam logic [2:0] ERR_UNIT    = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;

  // Counter width covers the whole timeout range; the timeout fires on the
  // cycle the counter would step onto TIMEOUT_CYCLES-1, so the error strobe
  // coincides with the counter reaching that value.
  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [2:0]     MAX_DIG = 3'(MAX_DIGITS);

  // Expected prefix character at each position of "distance: ".
  function automatic logic [7:0] prefix_char(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'h64; // d
      4'd1:    c = 8'h69; // i
      4'd2:    c = 8'h73; // s
      4'd3:    c = 8'h74; // t
      4'd4:    c = 8'h61; // a
      4'd5:    c = 8'h6E; // n
      4'd6:    c = 8'h63; // c
      4'd7:    c = 8'h65; // e
      4'd8:    c = 8'h3A; // :
      4'd9:    c = 8'h20; // space
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t          state_r;
  logic [3:0]      idx_r;
  logic [13:0]     acc_r;
  logic [2:0]      ndig_r;
  logic [TW-1:0]   to_cnt_r;

  logic            is_digit_s;
  logic [13:0]     acc_next_s;
  logic            counting_s;
  logic            prefix_hit_s;

  // The parser is always ready: every available byte is popped this cycle.
  assign rd = ~rx_empty & ~reset;

  // Byte classification, next accumulator value and timeout enable.
  always_comb begin
    is_digit_s   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    acc_next_s   = (acc_r << 3) + (acc_r << 1) + {10'd0, rx_data[3:0]};
    prefix_hit_s = (rx_data == prefix_char(idx_r));
    if ((state_r == ST_PREFIX) && (idx_r == 4'd0)) begin
      counting_s = 1'b0;
    end else begin
      counting_s = 1'b1;
    end
  end

  // Frame FSM with registered result/error strobes and inter-byte timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_PREFIX;
      idx_r      <= 4'd0;
      acc_r      <= 14'd0;
      ndig_r     <= 3'd0;
      to_cnt_r   <= '0;
      distance   <= 16'd0;
      dist_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 3'd0;
    end else begin
      dist_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!rx_empty) begin
        // A byte always wins over an expiring timeout.
        to_cnt_r <= '0;
        case (state_r)
          ST_PREFIX: begin
            if (prefix_hit_s) begin
              if (idx_r == 4'd9) begin
                state_r <= ST_DIGIT;
                idx_r   <= 4'd0;
                acc_r   <= 14'd0;
                ndig_r  <= 3'd0;
              end else begin
                idx_r <= idx_r + 4'd1;
              end
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_PREFIX;
              idx_r     <= 4'd0;
              state_r   <= (rx_data == CH_LF) ? ST_PREFIX : ST_RESYNC;
            end
          end
          ST_DIGIT: begin
            if (is_digit_s) begin
              if (ndig_r < MAX_DIG) begin
                acc_r  <= acc_next_s;
                ndig_r <= ndig_r + 3'd1;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_OVERFL;
                state_r   <= ST_RESYNC;
              end
            end else if (rx_data == CH_C) begin
              if (ndig_r != 3'd0) begin
                state_r <= ST_UNIT_M;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_NODIG;
                state_r   <= ST_RESYNC;
              end
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHAR;
              idx_r     <= 4'd0;
              state_r   <= (rx_data == CH_LF) ? ST_PREFIX : ST_RESYNC;
            end
          end
          ST_UNIT_M: begin
            if (rx_data == CH_M) begin
              state_r <= ST_EOL;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_UNIT;
              idx_r     <= 4'd0;
              state_r   <= (rx_data == CH_LF) ? ST_PREFIX : ST_RESYNC;
            end
          end
          ST_EOL: begin
            if (rx_data == CH_LF) begin
              distance   <= {2'b00, acc_r};
              dist_valid <= 1'b1;
              idx_r      <= 4'd0;
              state_r    <= ST_PREFIX;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_UNIT;
              state_r   <= ST_RESYNC;
            end
          end
          ST_RESYNC: begin
            if (rx_data == CH_LF) begin
              idx_r   <= 4'd0;
              state_r <= ST_PREFIX;
            end else begin
              state_r <= ST_RESYNC;
            end
          end
          default: begin
            idx_r   <= 4'd0;
            state_r <= ST_PREFIX;
          end
        endcase
      end else if (counting_s) begin
        if (to_cnt_r == TO_LAST) begin
          // Abandon the stalled frame; RESYNC drops silently.
          if (state_r != ST_RESYNC) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            frame_err <= 1'b0;
          end
          state_r  <= ST_PREFIX;
          idx_r    <= 4'd0;
          acc_r    <= 14'd0;
          ndig_r   <= 3'd0;
          to_cnt_r <= '0;
        end else begin
          to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end else begin
        to_cnt_r <= '0;
      end
    end
  end

endmodule

// File: doc/uart_distance_parser.md
Name: uart_distance_parser

Overview:
- Receive-side decoder for the ASCII distance frame emitted by the TX-side distance sender, in the form "distance: <1-3 digits>cm\n".
- Pops bytes from the UART RX FIFO, which is fed by uart_rx, and checks each frame character by character.
- Converts the decimal digits to binary and presents a validated 16-bit distance with a one-cycle valid strobe.
- Malformed, overlong or stalled frames are flagged and discarded; the parser then resynchronises on the next '\n'.

Parameters:
- MAX_DIGITS, 3, maximum number of decimal digits accepted per frame (1..4).
- TIMEOUT_CYCLES, 1_000_000, idle clk cycles allowed between bytes inside a frame before it is aborted (10 ms at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- rx_empty  input  1  RX FIFO empty flag
- rx_data  input  8  RX FIFO read data; show-ahead, valid whenever rx_empty=0
- rd  output  1  RX FIFO pop; combinational, equal to ~rx_empty outside reset
- distance  output  16  last successfully parsed distance in cm, zero-extended
- dist_valid  output  1  one-cycle pulse, asserted when distance updates
- frame_err  output  1  one-cycle pulse on any frame error
- err_code  output  3  cause of the most recent error, held until the next error: 1=prefix mismatch, 2=bad digit/char, 3=digit overflow, 4=no digits, 5=bad unit/EOL, 6=timeout

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - distance=0, dist_valid=0, frame_err=0, err_code=0, rd=0.
  - State=PREFIX, idx=0, acc=0, ndig=0, timeout counter=0.
  - Reset asserted mid-frame discards the partial frame; no strobe is produced.
- Byte consumption:
  - The parser is always ready. Each cycle with rx_empty=0, rd=1 and rx_data is consumed that same cycle.
  - Throughput is one byte per clk.
- PREFIX (idx 0..9, string "distance: "):
  - rx_data == string[idx]: idx++. A match at idx 9 goes to DIGIT with acc=0, ndig=0.
  - Mismatch with byte '\n': error 1, stay in PREFIX with idx=0.
  - Any other mismatch: error 1, go to RESYNC.
- DIGIT:
  - '0'..'9' with ndig<MAX_DIGITS: acc = acc*10 + (byte-48), ndig++. Leading zeros are accepted ("007" gives 7).
  - A digit with ndig==MAX_DIGITS: error 3, go to RESYNC.
  - 'c' with ndig>0: go to UNIT_M. 'c' with ndig==0: error 4, go to RESYNC.
  - Any other byte: error 2. If the byte is '\n', go to PREFIX idx 0; otherwise go to RESYNC.
- UNIT_M:
  - 'm': go to EOL.
  - Otherwise: error 5. '\n' goes to PREFIX idx 0; any other byte goes to RESYNC.
- EOL:
  - '\n': distance <= acc and dist_valid=1 on the next cycle (latency 1 clk after the '\n' pop); then PREFIX idx 0.
  - Otherwise: error 5, go to RESYNC.
- RESYNC:
  - Discard bytes until '\n' is consumed, then go to PREFIX idx 0.
  - No further errors are raised while in RESYNC.
- Error handling:
  - frame_err pulses exactly one cycle, registered, in the cycle after the offending pop.
  - err_code updates in the same cycle as the frame_err pulse.
  - distance is never modified on an error.
- Timeout:
  - The counter clears on every pop.
  - It increments while rx_empty=1, except when the state is PREFIX idx 0.
  - On reaching TIMEOUT_CYCLES-1: error 6, go to PREFIX idx 0, clear acc and ndig.
  - RESYNC also times out, to PREFIX idx 0, but without raising an error.
  - If the timeout expires in the same cycle a byte becomes available, the byte takes priority and the timeout does not fire.
- Width rules:
  - acc is 14 bits, sized for MAX_DIGITS=4 (9999).
  - The value is zero-extended to 16 bits.
  - No saturation is needed; overflow is prevented by the digit limit.
- Back-to-back frames with no gap parse correctly, with one dist_valid per frame.

Test Plan:
- Push "distance: 123cm\n" into the FIFO, one byte per cycle -> 16 pops; dist_valid pulses once, 1 clk after the '\n' pop; distance=123, frame_err never asserted.
- Push "distance: 7cm\n" then immediately "distance: 45cm\n" -> two dist_valid pulses; distance reads 7, then 45.
- Push "distance: 1234cm\n", then "distance: 9cm\n" -> frame_err with err_code=3 on the 4th digit, distance unchanged (previous value); the second frame gives distance=9.
- Push "distancX 5cm\n", then "distance: cm\n" -> err_code=1 then err_code=4, one frame_err pulse each; no dist_valid.
- Push "distance: 12", stall with FIFO empty for TIMEOUT_CYCLES (override to 100) -> frame_err with err_code=6 at cycle 99 of the stall; then "distance: 88cm\n" gives distance=88.
- Assert reset after "distance: 5" has been popped, then push "cm\n" -> no dist_valid, err_code=1 (prefix mismatch on 'c'), RESYNC consumes through '\n'; all outputs read 0 during reset.
